onchip_mem_dp_clr: RTL and testbench
====================================

Name: onchip_mem_dp_clr

Overview:
- Parametrised true dual-port on-chip RAM with two Avalon-MM slaves (s1, s2) for the camera Qsys system.
- Shared between the Nios control path and the VIP frame/line-buffer logic.
- Adds the following, which the existing single-port memory lacks: configurable width/depth, 1- or 2-cycle read latency with readdatavalid, waitrequest, optional hardware clear after reset, and defined collision rules.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 15, word-address width.
- DEPTH, 32000, number of words; must satisfy DEPTH <= 2**ADDR_W.
- READ_LAT, 1, read latency in clocks; legal values 1 or 2 (2 adds an output register).
- CLEAR_ON_RESET, 1, when 1, write CLEAR_VALUE to every word after reset.
- CLEAR_VALUE, 0, DATA_W-bit fill value.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- clken  in  1  global clock enable; 0 stalls the whole block.
- s1_address  in  ADDR_W  port 1 word address.
- s1_byteenable  in  DATA_W/8  port 1 byte lanes.
- s1_chipselect, s1_read, s1_write  in  1 each  port 1 command qualifiers.
- s1_writedata  in  DATA_W  port 1 write data.
- s1_readdata  out  DATA_W  port 1 read data.
- s1_readdatavalid  out  1  port 1 read data valid.
- s1_waitrequest  out  1  port 1 stall.
- s2_*  same set as s1_*, for port 2.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset: single clock `clk`; reset is asynchronous and active-high. Asynchronous reset applies every output reset value immediately; clear counter goes to 0.
- Reset values:
  - readdata = 0 and readdatavalid = 0 on both ports.
  - waitrequest = 1 and busy = 1 when CLEAR_ON_RESET = 1; otherwise both 0.
- FSM states: CLEAR, RUN.
  - Reset enters CLEAR when CLEAR_ON_RESET = 1, else RUN.
  - CLEAR: each clken cycle writes CLEAR_VALUE (all lanes) to address cnt, then cnt++.
  - CLEAR -> RUN on the cycle that writes cnt = DEPTH-1. busy and waitrequest fall in the first RUN cycle.
  - Reset asserted mid-clear restarts the clear from address 0.
- Accept rule: a port accepts a command when chipselect & (read | write) & ~waitrequest & clken.
  - In RUN, waitrequest = ~clken.
  - read and write asserted together on one port: treat as a write; no readdatavalid.
- Write: writes only the lanes set in byteenable. byteenable = 0 is a legal no-op.
- Read: readdatavalid pulses exactly READ_LAT enabled cycles after accept; readdata is held until the next valid.
  - Back-to-back reads give one valid per cycle with no bubbles.
  - readdata is undefined when readdatavalid = 0, but the bench expects it held.
- Out of range (address >= DEPTH): writes are dropped; reads return 0 with normal latency and valid.
- clken = 0: memory, read pipeline and FSM all freeze; no valid is lost or duplicated.
- Same-port read-during-write cannot occur, since one command per port per cycle.
- Cross-port, same address, same cycle:
  - Write/write: lanes enabled on s1 take s1 data; lanes enabled only on s2 take s2 data.
  - Read/write: the read returns OLD data.
- Width rule: byteenable width is DATA_W/8; the address is compared unsigned against DEPTH.

Decomposition:
- Shared package: function `clog2`; typedef `state_e` {CLEAR, RUN}; localparam BE_W = DATA_W/8.
- One sub-module, onchip_mem_rdpipe: per-port valid/data shift pipeline of depth READ_LAT, clken-gated, async reset. It is instantiated twice.
- Storage stays in the top level as an inferred true-dual-port array with per-lane write enables.

Test Plan:
- Clear sequence: DEPTH=16, CLEAR_ON_RESET=1, CLEAR_VALUE=0xA5A5A5A5; release reset -> busy high exactly 16 cycles; afterwards every s1 read returns 0xA5A5A5A5.
- Byte lanes and latency: s1 writes 0x11223344 be=0xF to addr 3, then 0xFF00_0000 be=0x8 -> s2 read of addr 3 returns 0xFF223344, valid exactly READ_LAT cycles after accept (check both 1 and 2).
- Collision: same cycle, s1 write 0xAAAAAAAA be=0x3 and s2 write 0xBBBBBBBB be=0xE to addr 7 -> readback 0xBBBBAAAA.
- Read/write collision: addr 5 holds 0x1; s1 write 0x2 while s2 reads 5 -> s2 gets 0x1; next s2 read gets 0x2.
- Stall: reads to addrs 0..3 issued back-to-back, clken dropped 3 cycles mid-stream -> exactly 4 valids, in order, none duplicated; waitrequest = 1 during the stall.
- Reset and range: reset asserted at clear cnt = 8 -> busy restarts and lasts a full DEPTH; read of addr = DEPTH -> returns 0 with valid; write to it does not alias addr 0.

Source files
------------

// File: rtl/onchip_mem_dp_clr_pkg.sv
// Purpose: shared types and helpers for the dual-port on-chip RAM with clear.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_e (CLEAR/RUN), clog2() index-width helper, default lane count.
package onchip_mem_dp_clr_pkg;

  // Clear sequencer states.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Default data width and its byte-lane count. Modules with a different
  // DATA_W derive their own lane count locally.
  localparam int DEF_DATA_W = 32;
  localparam int BE_W       = DEF_DATA_W / 8;

  // Ceiling log2, floored at 1 so a 1-word memory still has a legal index.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/onchip_mem_rdpipe.sv
// Purpose: per-port read-return pipeline (valid, out-of-range flag, data).
// Latency: READ_LAT (1 or 2) enabled clocks from accept to out_vld.
// Backpressure: none; clken = 0 freezes every stage and masks out_vld.
// Ports: clk/reset/clken; acc_vld/acc_oor (read accepted, address out of
//        range); ram_dat (registered RAM read, valid one cycle after accept);
//        out_vld/out_dat (readdatavalid/readdata, data held between valids).
module onchip_mem_rdpipe
  import onchip_mem_dp_clr_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  input  logic              acc_vld,
  input  logic              acc_oor,
  input  logic [DATA_W-1:0] ram_dat,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_dat
);

  logic              vld1_q, vld1_d;
  logic              oor1_q, oor1_d;
  logic              vld2_q, vld2_d;
  logic [DATA_W-1:0] dat2_q, dat2_d;
  logic [DATA_W-1:0] dat1;

  // The RAM read register only reloads on an accepted read, and the range
  // flag likewise, so stage-1 data is naturally held until the next read.
  assign dat1 = oor1_q ? '0 : ram_dat;

  always_comb begin
    vld1_d = vld1_q;
    oor1_d = oor1_q;
    vld2_d = vld2_q;
    dat2_d = dat2_q;
    if (clken) begin
      vld1_d = acc_vld;
      if (acc_vld) begin
        oor1_d = acc_oor;
      end
      vld2_d = vld1_q;
      if (vld1_q) begin
        dat2_d = dat1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld1_q <= 1'b0;
      oor1_q <= 1'b0;
      vld2_q <= 1'b0;
      dat2_q <= '0;
    end else begin
      vld1_q <= vld1_d;
      oor1_q <= oor1_d;
      vld2_q <= vld2_d;
      dat2_q <= dat2_d;
    end
  end

  // Valid is masked while stalled so a frozen stage is never seen twice.
  assign out_vld = clken & ((READ_LAT == 2) ? vld2_q : vld1_q);
  assign out_dat = (READ_LAT == 2) ? dat2_q : dat1;

endmodule

// File: rtl/onchip_mem_dp_clr.sv
// Purpose: true dual-port on-chip RAM, two Avalon-MM slaves, optional clear after reset.
// Latency: reads return READ_LAT (1 or 2) enabled clocks after accept; writes take effect next edge.
// Backpressure: waitrequest high during the clear sequence and whenever clken = 0.
// Ports: clk, reset (async, active high), clken (global stall); per port sN_address,
//        sN_byteenable, sN_chipselect/read/write, sN_writedata in; sN_readdata,
//        sN_readdatavalid, sN_waitrequest out; busy out while clearing.
module onchip_mem_dp_clr
  import onchip_mem_dp_clr_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 15,
  parameter int                DEPTH          = 32000,
  parameter int                READ_LAT       = 1,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clken,
  input  logic [ADDR_W-1:0]      s1_address,
  input  logic [DATA_W/8-1:0]    s1_byteenable,
  input  logic                   s1_chipselect,
  input  logic                   s1_read,
  input  logic                   s1_write,
  input  logic [DATA_W-1:0]      s1_writedata,
  output logic [DATA_W-1:0]      s1_readdata,
  output logic                   s1_readdatavalid,
  output logic                   s1_waitrequest,
  input  logic [ADDR_W-1:0]      s2_address,
  input  logic [DATA_W/8-1:0]    s2_byteenable,
  input  logic                   s2_chipselect,
  input  logic                   s2_read,
  input  logic                   s2_write,
  input  logic [DATA_W-1:0]      s2_writedata,
  output logic [DATA_W-1:0]      s2_readdata,
  output logic                   s2_readdatavalid,
  output logic                   s2_waitrequest,
  output logic                   busy
);

  localparam int              LANES     = DATA_W / 8;
  localparam int              IDX_W     = clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam state_e          RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    if (state_q == CLEAR && clken) begin
      clr_we = 1'b1;
      cnt_d  = cnt_q + 1'b1;
      // Leave CLEAR on the edge that writes the last word.
      if (cnt_q == LAST) begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == CLEAR);

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  logic             stall;
  logic             s1_sel, s1_wr_acc, s1_rd_acc, s1_in_rng;
  logic             s2_sel, s2_wr_acc, s2_rd_acc, s2_in_rng;
  logic [LANES-1:0] s1_lane_we, s2_lane_we;
  logic [IDX_W-1:0] s1_idx, s2_idx;

  assign stall          = busy | ~clken;
  assign s1_waitrequest = stall;
  assign s2_waitrequest = stall;

  // Commands are ignored while reset is held, even with the clear disabled.
  assign s1_sel    = s1_chipselect & ~stall & ~reset;
  assign s1_wr_acc = s1_sel & s1_write;
  // read+write together is a write only.
  assign s1_rd_acc = s1_sel & s1_read & ~s1_write;
  assign s1_in_rng = ({1'b0, s1_address} < DEPTH_X);
  assign s1_idx    = s1_address[IDX_W-1:0];
  assign s1_lane_we = {LANES{s1_wr_acc & s1_in_rng}} & s1_byteenable;

  assign s2_sel    = s2_chipselect & ~stall & ~reset;
  assign s2_wr_acc = s2_sel & s2_write;
  assign s2_rd_acc = s2_sel & s2_read & ~s2_write;
  assign s2_in_rng = ({1'b0, s2_address} < DEPTH_X);
  assign s2_idx    = s2_address[IDX_W-1:0];
  assign s2_lane_we = {LANES{s2_wr_acc & s2_in_rng}} & s2_byteenable;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];

  // s2 lanes are written first so that, on the same word, any lane also
  // enabled on s1 is overwritten by s1 (later NBA wins).
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q[IDX_W-1:0]] <= CLEAR_VALUE;
    end
    for (int b = 0; b < LANES; b++) begin
      if (s2_lane_we[b]) begin
        mem[s2_idx][b*8 +: 8] <= s2_writedata[b*8 +: 8];
      end
      if (s1_lane_we[b]) begin
        mem[s1_idx][b*8 +: 8] <= s1_writedata[b*8 +: 8];
      end
    end
  end

  // Registered read ports sampled straight from the array: a cross-port write
  // on the same edge is not yet visible, giving read-old-data behaviour.
  // Out-of-range reads load a don't-care word that the pipeline masks to 0.
  logic [DATA_W-1:0] s1_ram_q, s2_ram_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_ram_q <= '0;
      s2_ram_q <= '0;
    end else begin
      if (s1_rd_acc) begin
        s1_ram_q <= mem[s1_idx];
      end
      if (s2_rd_acc) begin
        s2_ram_q <= mem[s2_idx];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read return pipelines
  // ---------------------------------------------------------------------------
  onchip_mem_rdpipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_rdpipe_s1 (
    .clk     (clk),
    .reset   (reset),
    .clken   (clken),
    .acc_vld (s1_rd_acc),
    .acc_oor (~s1_in_rng),
    .ram_dat (s1_ram_q),
    .out_vld (s1_readdatavalid),
    .out_dat (s1_readdata)
  );

  onchip_mem_rdpipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_rdpipe_s2 (
    .clk     (clk),
    .reset   (reset),
    .clken   (clken),
    .acc_vld (s2_rd_acc),
    .acc_oor (~s2_in_rng),
    .ram_dat (s2_ram_q),
    .out_vld (s2_readdatavalid),
    .out_dat (s2_readdata)
  );

endmodule

// File: tb/tb_onchip_mem_dp_clr.sv
// Purpose: directed bench for onchip_mem_dp_clr; two instances share stimulus,
//          one with READ_LAT=1 (a_*) and one with READ_LAT=2 (b_*).
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: clken driven by the bench; commands held while stalled.
module tb_onchip_mem_dp_clr;

  localparam logic [31:0] CV = 32'hA5A5A5A5;

  logic        clk, reset, clken;
  logic [4:0]  s1_address, s2_address;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic        s1_chipselect, s1_read, s1_write;
  logic        s2_chipselect, s2_read, s2_write;
  logic [31:0] s1_writedata, s2_writedata;

  logic [31:0] a_s1_readdata, a_s2_readdata, b_s1_readdata, b_s2_readdata;
  logic        a_s1_readdatavalid, a_s2_readdatavalid, b_s1_readdatavalid, b_s2_readdatavalid;
  logic        a_s1_waitrequest, a_s2_waitrequest, b_s1_waitrequest, b_s2_waitrequest;
  logic        a_busy, b_busy;

  int checks = 0;
  int errors = 0;

  onchip_mem_dp_clr #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(16), .READ_LAT(1),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
  ) dut_a (
    .clk(clk), .reset(reset), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(a_s1_readdata), .s1_readdatavalid(a_s1_readdatavalid), .s1_waitrequest(a_s1_waitrequest),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(a_s2_readdata), .s2_readdatavalid(a_s2_readdatavalid), .s2_waitrequest(a_s2_waitrequest),
    .busy(a_busy)
  );

  onchip_mem_dp_clr #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(16), .READ_LAT(2),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
  ) dut_b (
    .clk(clk), .reset(reset), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(b_s1_readdata), .s1_readdatavalid(b_s1_readdatavalid), .s1_waitrequest(b_s1_waitrequest),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(b_s2_readdata), .s2_readdatavalid(b_s2_readdatavalid), .s2_waitrequest(b_s2_waitrequest),
    .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = 0; s1_byteenable = 0; s1_writedata = 0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = 0; s2_byteenable = 0; s2_writedata = 0;
  endtask

  task automatic drv1(input logic rd, input logic wr, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    s1_chipselect = 1; s1_read = rd; s1_write = wr; s1_address = a; s1_writedata = d; s1_byteenable = be;
  endtask

  task automatic drv2(input logic rd, input logic wr, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    s2_chipselect = 1; s2_read = rd; s2_write = wr; s2_address = a; s2_writedata = d; s2_byteenable = be;
  endtask

  // Counts samples with a_busy high, starting from the current sample.
  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (a_busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL %s: busy high for %0d cycles, required 16", name, n);
    end
    checks++;
    if (a_s1_waitrequest !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_run: waitrequest=%b b_busy=%b, required 0 0", name, a_s1_waitrequest, b_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1; clken = 1; idle();
    repeat (3) step();
    checks++;
    if (a_s1_readdata !== 0 || a_s2_readdata !== 0 || b_s1_readdata !== 0 || b_s2_readdata !== 0) begin
      errors++;
      $display("FAIL reset_rdata: %h %h %h %h, required all 0", a_s1_readdata, a_s2_readdata, b_s1_readdata, b_s2_readdata);
    end
    checks++;
    if ({a_s1_readdatavalid, a_s2_readdatavalid, b_s1_readdatavalid, b_s2_readdatavalid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_valid: %b%b%b%b, required 0000", a_s1_readdatavalid, a_s2_readdatavalid, b_s1_readdatavalid, b_s2_readdatavalid);
    end
    checks++;
    if ({a_s1_waitrequest, a_s2_waitrequest, a_busy, b_busy} !== 4'b1111) begin
      errors++;
      $display("FAIL reset_wait_busy: %b%b%b%b, required 1111", a_s1_waitrequest, a_s2_waitrequest, a_busy, b_busy);
    end
  endtask

  task automatic test_clear();
    reset = 0;
    count_busy("clear_busy");
    for (int i = 0; i < 16; i++) begin
      drv1(1, 0, 5'(i), 0, 0);
      step();
      checks++;
      if (a_s1_readdatavalid !== 1'b1 || a_s1_readdata !== CV) begin
        errors++;
        $display("FAIL clear_rd_a[%0d]: valid=%b data=%h, required 1 %h", i, a_s1_readdatavalid, a_s1_readdata, CV);
      end
      checks++;
      if (b_s1_readdatavalid !== (i > 0) || (i > 0 && b_s1_readdata !== CV)) begin
        errors++;
        $display("FAIL clear_rd_b[%0d]: valid=%b data=%h, required %0d %h", i, b_s1_readdatavalid, b_s1_readdata, (i > 0), CV);
      end
    end
    idle();
    step();
    checks++;
    if (b_s1_readdatavalid !== 1'b1 || b_s1_readdata !== CV || a_s1_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL clear_tail: b_valid=%b b_data=%h a_valid=%b, required 1 %h 0", b_s1_readdatavalid, b_s1_readdata, a_s1_readdatavalid, CV);
    end
  endtask

  task automatic test_byte_lanes();
    drv1(0, 1, 3, 32'h11223344, 4'hF); step();
    drv1(0, 1, 3, 32'hFF000000, 4'h8); step();
    idle();
    drv2(1, 0, 3, 0, 0); step();
    idle();
    checks++;
    if (a_s2_readdatavalid !== 1'b1 || a_s2_readdata !== 32'hFF223344 || b_s2_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL lanes_lat1: a_valid=%b a_data=%h b_valid=%b, required 1 ff223344 0", a_s2_readdatavalid, a_s2_readdata, b_s2_readdatavalid);
    end
    step();
    checks++;
    if (b_s2_readdatavalid !== 1'b1 || b_s2_readdata !== 32'hFF223344 || a_s2_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL lanes_lat2: b_valid=%b b_data=%h a_valid=%b, required 1 ff223344 0", b_s2_readdatavalid, b_s2_readdata, a_s2_readdatavalid);
    end
    checks++;
    if (a_s2_readdata !== 32'hFF223344) begin
      errors++;
      $display("FAIL lanes_hold: a_data=%h, required ff223344", a_s2_readdata);
    end
  endtask

  task automatic test_collision();
    drv1(0, 1, 7, 32'hAAAAAAAA, 4'h3);
    drv2(0, 1, 7, 32'hBBBBBBBB, 4'hE);
    step();
    idle();
    drv1(1, 0, 7, 0, 0); step();
    idle();
    checks++;
    if (a_s1_readdatavalid !== 1'b1 || a_s1_readdata !== 32'hBBBBAAAA) begin
      errors++;
      $display("FAIL ww_collision_a: valid=%b data=%h, required 1 bbbbaaaa", a_s1_readdatavalid, a_s1_readdata);
    end
    step();
    checks++;
    if (b_s1_readdatavalid !== 1'b1 || b_s1_readdata !== 32'hBBBBAAAA) begin
      errors++;
      $display("FAIL ww_collision_b: valid=%b data=%h, required 1 bbbbaaaa", b_s1_readdatavalid, b_s1_readdata);
    end
  endtask

  task automatic test_rw_collision();
    drv1(0, 1, 5, 32'h1, 4'hF); step();
    drv1(0, 1, 5, 32'h2, 4'hF);
    drv2(1, 0, 5, 0, 0);
    step();
    idle();
    checks++;
    if (a_s2_readdatavalid !== 1'b1 || a_s2_readdata !== 32'h1) begin
      errors++;
      $display("FAIL rw_old_a: valid=%b data=%h, required 1 00000001", a_s2_readdatavalid, a_s2_readdata);
    end
    step();
    checks++;
    if (b_s2_readdatavalid !== 1'b1 || b_s2_readdata !== 32'h1) begin
      errors++;
      $display("FAIL rw_old_b: valid=%b data=%h, required 1 00000001", b_s2_readdatavalid, b_s2_readdata);
    end
    drv2(1, 0, 5, 0, 0); step();
    idle();
    checks++;
    if (a_s2_readdatavalid !== 1'b1 || a_s2_readdata !== 32'h2) begin
      errors++;
      $display("FAIL rw_new_a: valid=%b data=%h, required 1 00000002", a_s2_readdatavalid, a_s2_readdata);
    end
    step();
    checks++;
    if (b_s2_readdatavalid !== 1'b1 || b_s2_readdata !== 32'h2) begin
      errors++;
      $display("FAIL rw_new_b: valid=%b data=%h, required 1 00000002", b_s2_readdatavalid, b_s2_readdata);
    end
  endtask

  task automatic test_same_port_rw();
    // read+write together is a write with no return; byteenable=0 is a no-op.
    drv1(1, 1, 9, 32'h12345678, 4'hF); step();
    idle();
    checks++;
    if (a_s1_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL rdwr_novalid_a: valid=%b, required 0", a_s1_readdatavalid);
    end
    drv1(0, 1, 9, 32'hFFFFFFFF, 4'h0); step();
    idle();
    checks++;
    if (b_s1_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL rdwr_novalid_b: valid=%b, required 0", b_s1_readdatavalid);
    end
    drv1(1, 0, 9, 0, 0); step();
    idle();
    checks++;
    if (a_s1_readdatavalid !== 1'b1 || a_s1_readdata !== 32'h12345678) begin
      errors++;
      $display("FAIL rdwr_readback: valid=%b data=%h, required 1 12345678", a_s1_readdatavalid, a_s1_readdata);
    end
    step();
  endtask

  task automatic test_back_to_back_stall();
    int p, ka, kb;
    logic en;
    for (int i = 0; i < 4; i++) begin
      drv1(0, 1, 5'(i), 32'h100 + i, 4'hF);
      step();
    end
    idle();
    step();
    p = 0; ka = 0; kb = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      en = !(cyc >= 2 && cyc <= 4);
      clken = en;
      if (p < 4) drv1(1, 0, 5'(p), 0, 0);
      else idle();
      step();
      if (en && p < 4) p++;
      if (!en) begin
        checks++;
        if (a_s1_waitrequest !== 1'b1 || b_s1_waitrequest !== 1'b1) begin
          errors++;
          $display("FAIL stall_wait[%0d]: a=%b b=%b, required 1 1", cyc, a_s1_waitrequest, b_s1_waitrequest);
        end
      end
      if (a_s1_readdatavalid === 1'b1) begin
        checks++;
        if (ka >= 4 || a_s1_readdata !== 32'h100 + ka) begin
          errors++;
          $display("FAIL stall_order_a[%0d]: data=%h, required %h", ka, a_s1_readdata, 32'h100 + ka);
        end
        ka++;
      end
      if (b_s1_readdatavalid === 1'b1) begin
        checks++;
        if (kb >= 4 || b_s1_readdata !== 32'h100 + kb) begin
          errors++;
          $display("FAIL stall_order_b[%0d]: data=%h, required %h", kb, b_s1_readdata, 32'h100 + kb);
        end
        kb++;
      end
    end
    clken = 1;
    idle();
    checks++;
    if (ka !== 4 || kb !== 4) begin
      errors++;
      $display("FAIL stall_count: a=%0d b=%0d valids, required 4 4", ka, kb);
    end
  endtask

  task automatic test_reset_mid_clear();
    reset = 1;
    #1;
    checks++;
    if (a_s1_readdata !== 0 || b_s1_readdata !== 0 || a_busy !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: a_data=%h b_data=%h busy=%b, required 0 0 1", a_s1_readdata, b_s1_readdata, a_busy);
    end
    step(); step();
    reset = 0;
    repeat (8) step();
    checks++;
    if (a_busy !== 1'b1) begin
      errors++;
      $display("FAIL midclear_busy: busy=%b, required 1", a_busy);
    end
    reset = 1;
    step(); step();
    reset = 0;
    count_busy("restart_busy");
  endtask

  task automatic test_range();
    drv1(0, 1, 16, 32'hDEADBEEF, 4'hF); step();
    drv1(1, 0, 0, 0, 0); step();
    checks++;
    if (a_s1_readdatavalid !== 1'b1 || a_s1_readdata !== CV) begin
      errors++;
      $display("FAIL range_noalias: valid=%b data=%h, required 1 %h", a_s1_readdatavalid, a_s1_readdata, CV);
    end
    drv1(1, 0, 16, 0, 0); step();
    idle();
    checks++;
    if (a_s1_readdatavalid !== 1'b1 || a_s1_readdata !== 0) begin
      errors++;
      $display("FAIL range_rd_a: valid=%b data=%h, required 1 00000000", a_s1_readdatavalid, a_s1_readdata);
    end
    checks++;
    if (b_s1_readdatavalid !== 1'b1 || b_s1_readdata !== CV) begin
      errors++;
      $display("FAIL range_prev_b: valid=%b data=%h, required 1 %h", b_s1_readdatavalid, b_s1_readdata, CV);
    end
    step();
    checks++;
    if (b_s1_readdatavalid !== 1'b1 || b_s1_readdata !== 0) begin
      errors++;
      $display("FAIL range_rd_b: valid=%b data=%h, required 1 00000000", b_s1_readdatavalid, b_s1_readdata);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_byte_lanes();
    test_collision();
    test_rw_collision();
    test_same_port_rw();
    test_back_to_back_stall();
    test_reset_mid_clear();
    test_range();
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
